// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target: FSM state encoding,
// default device address and ACK/NACK line levels.
package sccb_pkg;

   localparam int         BYTE_W         = 8;
   localparam logic [6:0] DEV_ID_DEFAULT = 7'h21;
   localparam logic       ACK_BIT        = 1'b0;
   localparam logic       NACK_BIT       = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_ID        = 4'd1,
      S_ID_ACK    = 4'd2,
      S_SUBADDR   = 4'd3,
      S_SUB_ACK   = 4'd4,
      S_WDATA     = 4'd5,
      S_WDATA_ACK = 4'd6,
      S_RDATA     = 4'd7,
      S_RDATA_ACK = 4'd8,
      S_IGNORE    = 4'd9
   } state_t;

endpackage

// File: rtl/sccb_target_if.sv
// SCCB bus lines as seen by the target: SCL and the sampled SDA level in,
// the SDA drive value and drive enable out.
interface sccb_target_if;
   logic c_SCL;
   logic r_SDA;
   logic t_SDA;
   logic drive_SDA;

   modport master (output c_SCL, output r_SDA, input t_SDA, input drive_SDA);
   modport slave  (input c_SCL, input r_SDA, output t_SDA, output drive_SDA);
endinterface

// File: rtl/sccb_line_sync.sv
// Synchronises SCL/SDA into the clk_50MHz domain and produces single-cycle
// SCL edge and START/STOP condition pulses.
module sccb_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_50MHz,
   input  logic rst_n,
   input  logic c_SCL,
   input  logic r_SDA,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_pipe;
   logic [SYNC_STAGES-1:0] sda_pipe;
   logic                   scl_s;
   logic                   scl_q;
   logic                   sda_q;

   // Idle bus is high on both lines, so reset to 1 to avoid false edges.
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         scl_pipe <= '1;
         sda_pipe <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], c_SCL};
         sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], r_SDA};
         scl_q    <= scl_pipe[SYNC_STAGES-1];
         sda_q    <= sda_pipe[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_pipe[SYNC_STAGES-1];
   assign sda_s     = sda_pipe[SYNC_STAGES-1];
   assign scl_rise  =  scl_s & ~scl_q;
   assign scl_fall  = ~scl_s &  scl_q;
   assign start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
   assign stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/sccb_target.sv
// OV7670-style SCCB responder with a 256x8 register file; decodes 3-phase
// writes and 2-phase reads, and reports every committed write.
module sccb_target
   import sccb_pkg::*;
#(
   parameter logic [6:0] DEV_ID       = DEV_ID_DEFAULT,
   parameter int         SDA_HOLD_CYC = 4,
   parameter int         SYNC_STAGES  = 2
) (
   input  logic              clk_50MHz,
   input  logic              rst_n,
   sccb_target_if.slave      bus,
   output logic              wr_valid,
   output logic [BYTE_W-1:0] wr_addr,
   output logic [BYTE_W-1:0] wr_data,
   input  logic [BYTE_W-1:0] dbg_addr,
   output logic [BYTE_W-1:0] dbg_data,
   output logic              busy,
   output state_t            dbg_state
);

   localparam int HOLD_W = $clog2(SDA_HOLD_CYC + 1);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .c_SCL     (bus.c_SCL),
      .r_SDA     (bus.r_SDA),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   logic [BYTE_W-1:0] mem [256];
   state_t            state;
   logic [BYTE_W-1:0] ptr;
   logic [BYTE_W-1:0] sub_addr;
   logic [6:0]        shift_in;
   logic [6:0]        shift_out;
   logic [2:0]        bit_cnt;
   logic              rw;
   logic              ack_rise;
   logic [HOLD_W-1:0] hold_cnt;
   logic              t_sda_q;
   logic              drive_q;
   logic [BYTE_W-1:0] byte_in;
   logic              byte_done;
   logic              hold_fire;
   logic [BYTE_W-1:0] rd_addr;
   logic [BYTE_W-1:0] rd_byte;

   assign byte_in   = {shift_in, sda_s};
   assign byte_done = scl_rise && (bit_cnt == 3'd7);
   assign hold_fire = (hold_cnt == HOLD_W'(1));
   // A new read restarts from the last sub-address written; later bytes follow ptr.
   assign rd_addr   = (state == S_ID_ACK) ? sub_addr : ptr;
   assign rd_byte   = mem[rd_addr];

   // wr_valid is a single-cycle strobe with no back-pressure; wr_addr and
   // wr_data are meaningful only in the cycle wr_valid is high.
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ptr       <= '0;
         sub_addr  <= '0;
         shift_in  <= '0;
         shift_out <= '0;
         bit_cnt   <= '0;
         rw        <= 1'b0;
         ack_rise  <= 1'b0;
         hold_cnt  <= '0;
         t_sda_q   <= 1'b1;
         drive_q   <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         busy      <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         if (scl_fall)
            hold_cnt <= HOLD_W'(SDA_HOLD_CYC);
         else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - HOLD_W'(1);

         if (stop_det) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            drive_q <= 1'b0;
            t_sda_q <= 1'b1;
         end else if (start_det) begin
            state   <= S_ID;
            busy    <= 1'b1;
            bit_cnt <= '0;
            drive_q <= 1'b0;
            t_sda_q <= 1'b1;
         end else begin
            case (state)
               S_ID, S_SUBADDR, S_WDATA: begin
                  if (scl_rise) begin
                     shift_in <= byte_in[6:0];
                     bit_cnt  <= bit_cnt + 3'd1;
                  end
                  if (byte_done) begin
                     ack_rise <= 1'b0;
                     if (state == S_ID) begin
                        if (byte_in[7:1] == DEV_ID) begin
                           rw    <= byte_in[0];
                           state <= S_ID_ACK;
                        end else begin
                           state <= S_IGNORE;
                        end
                     end else if (state == S_SUBADDR) begin
                        ptr      <= byte_in;
                        sub_addr <= byte_in;
                        state    <= S_SUB_ACK;
                     end else begin
                        wr_valid <= 1'b1;
                        wr_addr  <= ptr;
                        wr_data  <= byte_in;
                        ptr      <= ptr + 8'd1;
                        state    <= S_WDATA_ACK;
                     end
                  end
               end
               S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                  if (scl_rise)
                     ack_rise <= 1'b1;
                  if (hold_fire && !ack_rise) begin
                     drive_q <= 1'b1;
                     t_sda_q <= ACK_BIT;
                  end else if (hold_fire) begin
                     bit_cnt <= '0;
                     if (state == S_ID_ACK && rw) begin
                        state     <= S_RDATA;
                        ptr       <= sub_addr;
                        shift_out <= rd_byte[6:0];
                        t_sda_q   <= rd_byte[7];
                     end else begin
                        state   <= (state == S_ID_ACK) ? S_SUBADDR : S_WDATA;
                        drive_q <= 1'b0;
                        t_sda_q <= 1'b1;
                     end
                  end
               end
               S_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state    <= S_RDATA_ACK;
                        ack_rise <= 1'b0;
                     end
                  end
                  if (hold_fire) begin
                     t_sda_q   <= shift_out[6];
                     shift_out <= {shift_out[5:0], 1'b0};
                  end
               end
               S_RDATA_ACK: begin
                  if (scl_rise) begin
                     if (sda_s == ACK_BIT) begin
                        ptr      <= ptr + 8'd1;
                        ack_rise <= 1'b1;
                     end else begin
                        state <= S_IGNORE;
                     end
                  end
                  if (hold_fire && !ack_rise) begin
                     drive_q <= 1'b0;
                     t_sda_q <= 1'b1;
                  end else if (hold_fire) begin
                     state     <= S_RDATA;
                     bit_cnt   <= '0;
                     drive_q   <= 1'b1;
                     shift_out <= rd_byte[6:0];
                     t_sda_q   <= rd_byte[7];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_50MHz) begin
      if (wr_valid)
         mem[wr_addr] <= wr_data;
   end

   assign dbg_data      = mem[dbg_addr];
   assign dbg_state     = state;
   assign bus.t_SDA     = t_sda_q;
   assign bus.drive_SDA = drive_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: an SCCB master model on an open-drain SDA line,
// a commit scoreboard and one task per scenario.
module tb_sccb_target;
   import sccb_pkg::*;

   localparam int Q = 640;

   logic       clk_50MHz = 1'b0;
   logic       rst_n;
   logic       scl_m;
   logic       sda_m;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] dbg_addr;
   logic [7:0] dbg_data;
   logic       busy;
   state_t     dbg_state;

   int          checks     = 0;
   int          failures   = 0;
   int          drive_seen = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  rd_q[$];
   logic [15:0] exp_commit;

   sccb_target_if bus();

   assign bus.c_SCL = scl_m;
   assign bus.r_SDA = sda_m & (bus.drive_SDA ? bus.t_SDA : 1'b1);

   sccb_target dut (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .bus       (bus),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   always @(negedge clk_50MHz) begin
      if (wr_valid === 1'b1) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL commit_unexpected: got addr=%h data=%h, expected no commit", wr_addr, wr_data);
         end else begin
            exp_commit = exp_q.pop_front();
            if ({wr_addr, wr_data} !== exp_commit) begin
               failures = failures + 1;
               $display("FAIL commit: got addr=%h data=%h, expected addr=%h data=%h",
                        wr_addr, wr_data, exp_commit[15:8], exp_commit[7:0]);
            end
         end
      end
      if (bus.drive_SDA === 1'b1)
         drive_seen = drive_seen + 1;
   end

   task automatic bus_start();
      scl_m = 1'b1; sda_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic bus_rstart();
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic [2:0] ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      ack = {bus.r_SDA, bus.drive_SDA, bus.t_SDA};
      #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic read_bit(output logic v);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      v = bus.r_SDA; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic read_byte(output logic [7:0] v);
      logic b;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         v = {v[6:0], b};
      end
   endtask

   task automatic settle();
      repeat (20) @(negedge clk_50MHz);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      scl_m = 1'b1;
      sda_m = 1'b1;
      dbg_addr = '0;
      repeat (4) @(negedge clk_50MHz);
      checks = checks + 1;
      if ({bus.drive_SDA, bus.t_SDA, wr_valid, busy} !== 4'b0100) begin
         failures = failures + 1;
         $display("FAIL reset_ctrl: got drive=%b t=%b wr_valid=%b busy=%b, expected 0 1 0 0",
                  bus.drive_SDA, bus.t_SDA, wr_valid, busy);
      end
      checks = checks + 1;
      if ({wr_addr, wr_data} !== 16'h0000) begin
         failures = failures + 1;
         $display("FAIL reset_wr: got addr=%h data=%h, expected 00 00", wr_addr, wr_data);
      end
      checks = checks + 1;
      if (dbg_state !== S_IDLE) begin
         failures = failures + 1;
         $display("FAIL reset_state: got %0d, expected %0d", dbg_state, S_IDLE);
      end
      rst_n = 1'b1;
      settle();
   endtask

   task automatic test_write();
      logic [2:0]  ack;
      logic [7:0]  bytes[3];
      bytes[0] = 8'h42; bytes[1] = 8'h12; bytes[2] = 8'h80;
      exp_q.push_back({8'h12, 8'h80});
      bus_start();
      checks = checks + 1;
      if (busy !== 1'b1) begin
         failures = failures + 1;
         $display("FAIL write_busy: got %b, expected 1", busy);
      end
      for (int i = 0; i < 3; i++) begin
         send_byte(bytes[i], ack);
         checks = checks + 1;
         if (ack !== 3'b010) begin
            failures = failures + 1;
            $display("FAIL write_ack%0d: got line/drive/t=%b, expected 010", i, ack);
         end
      end
      bus_stop();
      settle();
      dbg_addr = 8'h12;
      @(negedge clk_50MHz);
      checks = checks + 1;
      if (dbg_data !== 8'h80) begin
         failures = failures + 1;
         $display("FAIL write_mem: got %h, expected 80", dbg_data);
      end
      checks = checks + 1;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL write_end: got busy=%b pending=%0d, expected 0 0", busy, exp_q.size());
      end
   endtask

   task automatic test_read();
      logic [2:0] ack;
      logic [7:0] got;
      logic [7:0] exp;
      exp_q.push_back({8'h40, 8'hD0});
      bus_start();
      send_byte(8'h42, ack);
      send_byte(8'h40, ack);
      send_byte(8'hD0, ack);
      bus_rstart();
      send_byte(8'h43, ack);
      checks = checks + 1;
      if (ack !== 3'b010) begin
         failures = failures + 1;
         $display("FAIL read_id_ack: got line/drive/t=%b, expected 010", ack);
      end
      rd_q.push_back(8'hD0);
      read_byte(got);
      exp = rd_q.pop_front();
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL read_data: got %h, expected %h", got, exp);
      end
      sda_m = NACK_BIT; #Q;
      scl_m = 1'b1; #Q;
      checks = checks + 1;
      if (bus.drive_SDA !== 1'b0) begin
         failures = failures + 1;
         $display("FAIL read_na_release: got drive=%b, expected 0", bus.drive_SDA);
      end
      #Q;
      scl_m = 1'b0; #Q;
      bus_stop();
      settle();
      checks = checks + 1;
      if (busy !== 1'b0 || dbg_state !== S_IDLE) begin
         failures = failures + 1;
         $display("FAIL read_end: got busy=%b state=%0d, expected 0 %0d", busy, dbg_state, S_IDLE);
      end
   endtask

   task automatic test_wrong_id();
      logic [2:0] ack;
      drive_seen = 0;
      bus_start();
      send_byte(8'h60, ack);
      checks = checks + 1;
      if (ack[2] !== NACK_BIT) begin
         failures = failures + 1;
         $display("FAIL wrong_id_nack: got line=%b, expected 1", ack[2]);
      end
      send_byte(8'h12, ack);
      send_byte(8'h33, ack);
      bus_stop();
      settle();
      checks = checks + 1;
      if (drive_seen != 0) begin
         failures = failures + 1;
         $display("FAIL wrong_id_drive: got %0d driven cycles, expected 0", drive_seen);
      end
      dbg_addr = 8'h12;
      @(negedge clk_50MHz);
      checks = checks + 1;
      if (dbg_data !== 8'h80) begin
         failures = failures + 1;
         $display("FAIL wrong_id_mem: got %h, expected 80", dbg_data);
      end
   endtask

   task automatic test_burst_wrap();
      logic [2:0] ack;
      exp_q.push_back({8'hFF, 8'hAA});
      exp_q.push_back({8'h00, 8'hBB});
      bus_start();
      send_byte(8'h42, ack);
      send_byte(8'hFF, ack);
      send_byte(8'hAA, ack);
      send_byte(8'hBB, ack);
      checks = checks + 1;
      if (ack !== 3'b010) begin
         failures = failures + 1;
         $display("FAIL burst_ack: got line/drive/t=%b, expected 010", ack);
      end
      bus_stop();
      settle();
      dbg_addr = 8'hFF;
      @(negedge clk_50MHz);
      checks = checks + 1;
      if (dbg_data !== 8'hAA) begin
         failures = failures + 1;
         $display("FAIL burst_mem_ff: got %h, expected aa", dbg_data);
      end
      dbg_addr = 8'h00;
      @(negedge clk_50MHz);
      checks = checks + 1;
      if (dbg_data !== 8'hBB || exp_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL burst_mem_00: got %h pending=%0d, expected bb 0", dbg_data, exp_q.size());
      end
   endtask

   task automatic test_partial_stop();
      logic [2:0] ack;
      logic [3:0] part;
      part = 4'b1011;
      bus_start();
      send_byte(8'h42, ack);
      send_byte(8'h20, ack);
      for (int i = 3; i >= 0; i--) send_bit(part[i]);
      bus_stop();
      settle();
      checks = checks + 1;
      if (busy !== 1'b0 || dbg_state !== S_IDLE) begin
         failures = failures + 1;
         $display("FAIL partial_idle: got busy=%b state=%0d, expected 0 %0d", busy, dbg_state, S_IDLE);
      end
      exp_q.push_back({8'h3A, 8'h04});
      bus_start();
      send_byte(8'h42, ack);
      send_byte(8'h3A, ack);
      send_byte(8'h04, ack);
      bus_stop();
      settle();
      dbg_addr = 8'h3A;
      @(negedge clk_50MHz);
      checks = checks + 1;
      if (dbg_data !== 8'h04 || exp_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL partial_next: got %h pending=%0d, expected 04 0", dbg_data, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_read();
      logic [2:0] ack;
      logic       b;
      logic [7:0] got;
      logic [7:0] exp;
      bus_start();
      send_byte(8'h43, ack);
      read_bit(b);
      read_bit(b);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      rst_n = 1'b0;
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      checks = checks + 1;
      if (bus.drive_SDA !== 1'b0 || busy !== 1'b0) begin
         failures = failures + 1;
         $display("FAIL rst_mid_read: got drive=%b busy=%b, expected 0 0", bus.drive_SDA, busy);
      end
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      rst_n = 1'b1;
      #Q;
      scl_m = 1'b0; #Q;
      bus_stop();
      settle();
      // Reset cleared the pointer, so the fresh read starts at 0x00 (0xBB from the burst).
      bus_start();
      send_byte(8'h43, ack);
      checks = checks + 1;
      if (ack !== 3'b010) begin
         failures = failures + 1;
         $display("FAIL rst_read_ack: got line/drive/t=%b, expected 010", ack);
      end
      rd_q.push_back(8'hBB);
      read_byte(got);
      exp = rd_q.pop_front();
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL rst_read_data: got %h, expected %h", got, exp);
      end
      send_bit(NACK_BIT);
      bus_stop();
      settle();
      checks = checks + 1;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL rst_read_end: got busy=%b pending=%0d, expected 0 0", busy, exp_q.size());
      end
   endtask

   initial begin
      @(negedge clk_50MHz);
      test_reset();
      test_write();
      test_read();
      test_wrong_id();
      test_burst_wrap();
      test_partial_stop();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB/I2C-style responder: emulates the OV7670 camera side of the register bus.
- Decodes 3-phase writes and 2-phase reads sent by our SCCB master. Holds a 256x8 register file.
- Used as the on-FPGA and simulation target that closes the loop for the camera init sequencer. Every register the init table writes can be observed and read back.

Parameters:
- DEV_ID, 7'h21, 7-bit device address. Write byte 0x42, read byte 0x43.
- SDA_HOLD_CYC, 4, clk cycles after a synchronised SCL falling edge before SDA changes (data hold time).
- SYNC_STAGES, 2, flip-flop synchroniser depth on c_SCL and r_SDA.

Ports:
- clk_50MHz  in  1  system clock. Must be at least 32x the SCL rate; a 400 kHz SCL is the design maximum.
- rst_n  in  1  reset, synchronous, active-low.
- c_SCL  in  1  SCCB clock from the master.
- r_SDA  in  1  sampled SDA line.
- t_SDA  out  1  value driven onto SDA when drive_SDA=1.
- drive_SDA  out  1  1 = this block owns SDA.
- wr_valid  out  1  one-cycle pulse when a data byte is committed to the register file.
- wr_addr  out  8  register address of the committed byte.
- wr_data  out  8  committed data.
- dbg_addr  in  8  bench/debug read address.
- dbg_data  out  8  register file contents at dbg_addr, combinational.
- busy  out  1  high from START to STOP.

Behaviour:
- Reset values:
  - drive_SDA=0, t_SDA=1, wr_valid=0, wr_addr=0, wr_data=0, busy=0.
  - State IDLE, address pointer 0, bit counter 0.
  - Register file contents are not reset.
- Line sync and conditions:
  - SCL and SDA pass through SYNC_STAGES flops, then an edge detector.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
  - Data bits are sampled on the synchronised SCL rising edge, MSB first.
- ACK/response bit timing:
  - The ACK bit is the 9th bit of each byte.
  - SDA_HOLD_CYC cycles after the SCL falling edge that ends bit 8, drive drive_SDA=1, t_SDA=0.
  - Release drive_SDA SDA_HOLD_CYC cycles after the SCL falling edge that ends bit 9.
- State machine: IDLE, ID, ID_ACK, SUBADDR, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - IDLE -> ID on START.
  - ID, after 8 bits:
    - address mismatch -> IGNORE; never drive SDA.
    - match with R/W=0 -> ID_ACK, then SUBADDR.
    - match with R/W=1 -> ID_ACK, then RDATA.
  - SUBADDR: after 8 bits, pointer <= byte; -> SUB_ACK, then WDATA.
  - WDATA: after 8 bits, write mem[ptr] and pulse wr_valid with wr_addr=ptr, wr_data=byte (same cycle as the 8th rising edge).
    - Then ptr <= ptr+1 (8-bit, 0xFF wraps to 0x00).
    - -> WDATA_ACK, then WDATA again.
  - RDATA: load shift register with mem[ptr] on entry.
    - Each bit is driven with t_SDA=bit, SDA_HOLD_CYC cycles after SCL falls.
    - After 8 bits, release SDA -> RDATA_ACK.
  - RDATA_ACK: sample master bit on SCL rising edge.
    - 0 (ACK): ptr++ and -> RDATA.
    - 1 (NA): -> IGNORE.
  - IGNORE: holds until START or STOP.
- Global transitions, from any state:
  - STOP -> IDLE; release SDA within 1 cycle.
  - START (including repeated START) -> ID, bit counter cleared.
  - A STOP or START mid-byte discards the partial byte; no write is committed.
- The pointer persists across transactions: a 2-phase read returns mem[last sub-address written].
- busy goes 1 the cycle START is detected and 0 the cycle STOP is detected.
- rst_n low mid-transfer: outputs return to their reset values on the next clk edge, SDA is released, and the block waits for a fresh START.

Decomposition:
- sccb_pkg: state enum, DEV_ID default, ACK_BIT=1'b0, NACK_BIT=1'b1, byte-width constant.
- Sub-module sccb_line_sync: synchroniser plus scl_rise, scl_fall, start_det and stop_det pulses.

Test Plan:
- Write 0x42, 0x12, 0x80 then STOP at 400 kHz SCL:
  - wr_valid pulses once with wr_addr=0x12, wr_data=0x80.
  - drive_SDA=1, t_SDA=0 during all three 9th bits.
  - dbg_addr=0x12 gives dbg_data=0x80.
- Write 0x42, 0x40, 0xD0, then START, 0x43, read one byte, master NA, STOP:
  - Bits on SDA are 0xD0 MSB first.
  - SDA is released during the NA bit; busy=0 after STOP.
- Write with ID 0x60:
  - drive_SDA stays 0 for the whole transaction.
  - No wr_valid pulse; the register file is unchanged.
- Burst write 0x42, 0xFF, 0xAA, 0xBB:
  - Two wr_valid pulses: addr 0xFF data 0xAA, then addr 0x00 data 0xBB (wrap).
- STOP after 4 bits of a data byte, then a fresh write 0x42, 0x3A, 0x04:
  - No commit for the partial byte; next commit is addr 0x3A, data 0x04.
- Assert rst_n=0 for 2 cycles while driving the 3rd read bit:
  - drive_SDA=0 on the next edge; busy=0.
  - The next 0x43 read succeeds.
